// File: rtl/multi_toggle_detector.sv
// Multi-channel synchronised edge detector with per-channel pulse, sticky flag and saturating counter.
// Define DEBOUNCE_EN to insert a DEBOUNCE_CYCLES stability filter after each synchroniser.
module multi_toggle_detector #(
   parameter int unsigned CHANNELS        = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned CNT_WIDTH       = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [CHANNELS-1:0]           din,
   input  logic [1:0]                    mode,
   input  logic                          clear,
   output logic [CHANNELS-1:0]           pulse,
   output logic [CHANNELS-1:0]           sticky,
   output logic [CHANNELS*CNT_WIDTH-1:0] count,
   output logic                          any
);

   if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
      $error("CHANNELS must be within 1..32");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 1");
   end

   // Priming waits until the synchroniser (and filter) hold real samples, so a level
   // already present at reset release is never mistaken for an edge.
`ifdef DEBOUNCE_EN
   localparam int unsigned PRIME_EDGES = SYNC_STAGES + 2;
`else
   localparam int unsigned PRIME_EDGES = SYNC_STAGES + 1;
`endif
   localparam int unsigned FILL_W = $clog2(PRIME_EDGES + 1);

   logic [CHANNELS-1:0]           r_sync [SYNC_STAGES];
   logic [FILL_W-1:0]             r_fill;
   logic [CHANNELS-1:0]           r_prev;
   logic [CHANNELS-1:0]           r_pulse;
   logic [CHANNELS-1:0]           r_sticky;
   logic [CHANNELS*CNT_WIDTH-1:0] r_count;
   logic                          r_any;

   logic                          w_primed;
   logic [CHANNELS-1:0]           w_sync;
   logic [CHANNELS-1:0]           w_s;
   logic [CHANNELS-1:0]           w_rise;
   logic [CHANNELS-1:0]           w_fall;
   logic [CHANNELS-1:0]           w_event;

   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_primed = (r_fill == FILL_W'(PRIME_EDGES));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned st = 0; st < SYNC_STAGES; st++) begin
            r_sync[st] <= '0;
         end
      end else begin
         r_sync[0] <= din;
         for (int unsigned st = 1; st < SYNC_STAGES; st++) begin
            r_sync[st] <= r_sync[st-1];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_fill <= '0;
      end else if (!w_primed) begin
         r_fill <= r_fill + FILL_W'(1);
      end
   end

`ifdef DEBOUNCE_EN
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CHANNELS-1:0] r_lvl;
   logic [DB_W-1:0]     r_db_cnt [CHANNELS];

   // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_lvl <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            r_db_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!w_primed) begin
               r_lvl[i]    <= w_sync[i];
               r_db_cnt[i] <= '0;
            end else if (w_sync[i] == r_lvl[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               r_lvl[i]    <= w_sync[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign w_s = r_lvl;
`else
   assign w_s = w_sync;
`endif

   always_comb begin
      w_rise  = w_s & ~r_prev;
      w_fall  = ~w_s & r_prev;
      w_event = '0;
      if (w_primed) begin
         case (mode)
            2'b00:   w_event = w_rise | w_fall;
            2'b01:   w_event = w_rise;
            2'b10:   w_event = w_fall;
            default: w_event = '0;
         endcase
      end
   end

   // Clear outranks a same-cycle event for sticky/count; pulse is unaffected by clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_prev   <= '0;
         r_pulse  <= '0;
         r_sticky <= '0;
         r_count  <= '0;
         r_any    <= 1'b0;
      end else begin
         r_prev  <= w_s;
         r_pulse <= w_event;
         r_any   <= |r_pulse;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (clear) begin
               r_sticky[i]                       <= 1'b0;
               r_count[i*CNT_WIDTH +: CNT_WIDTH] <= '0;
            end else if (w_event[i]) begin
               r_sticky[i] <= 1'b1;
               if (r_count[i*CNT_WIDTH +: CNT_WIDTH] != {CNT_WIDTH{1'b1}}) begin
                  r_count[i*CNT_WIDTH +: CNT_WIDTH] <= r_count[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
               end
            end
         end
      end
   end

   assign pulse  = r_pulse;
   assign sticky = r_sticky;
   assign count  = r_count;
   assign any    = r_any;

endmodule

// File: tb/tb_multi_toggle_detector.sv
// Bench for multi_toggle_detector: history-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_multi_toggle_detector;

   localparam int N  = 4;
   localparam int S  = 2;
   localparam int CW = 4;
   localparam int D  = 4;
`ifdef DEBOUNCE_EN
   localparam int PRIME = S + 2;
   localparam int LAT   = S + D + 1;
`else
   localparam int PRIME = S + 1;
   localparam int LAT   = S + 1;
`endif
   localparam int HOLD = LAT + 2;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    din;
   logic [1:0]      mode;
   logic            clear;
   logic [N-1:0]    pulse;
   logic [N-1:0]    sticky;
   logic [N*CW-1:0] count;
   logic            any;

   int n_checks = 0;
   int n_fail   = 0;

   multi_toggle_detector #(
      .CHANNELS(N), .SYNC_STAGES(S), .CNT_WIDTH(CW), .DEBOUNCE_CYCLES(D)
   ) dut (
      .clock(clk), .reset(rst_n), .din(din), .mode(mode), .clear(clear),
      .pulse(pulse), .sticky(sticky), .count(count), .any(any)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an edge is a difference between the input as sampled S and S+1
   // edges ago (both after reset release), optionally filtered by a D-sample window.
   int              j;
   logic [N-1:0]    d_hist [$];
   logic [N-1:0]    r_hist [$];
   logic [N-1:0]    m_pulse, m_sticky, m_sprev, m_lvl;
   logic [CW-1:0]   m_cnt [N];
   logic            m_any;
   logic [N*CW-1:0] m_count_flat;

   always @(posedge clk) begin : model
      logic [N-1:0] rj, sv, rise, fall, ev;
      logic         flip;
      if (!rst_n) begin
         j = 0;
         d_hist.delete();
         r_hist.delete();
         m_pulse  = '0;
         m_sticky = '0;
         m_sprev  = '0;
         m_lvl    = '0;
         m_any    = 1'b0;
         for (int c = 0; c < N; c++) m_cnt[c] = '0;
      end else begin
         j++;
         d_hist.push_back(din);
         rj = (j > S) ? d_hist[j-S-1] : '0;
         r_hist.push_back(rj);
`ifdef DEBOUNCE_EN
         sv = m_lvl;
         if (j <= PRIME) begin
            m_lvl = rj;
         end else if (r_hist.size() >= D) begin
            for (int c = 0; c < N; c++) begin
               flip = 1'b1;
               for (int k = 1; k <= D; k++)
                  if (r_hist[r_hist.size()-k][c] == m_lvl[c]) flip = 1'b0;
               if (flip) m_lvl[c] = ~m_lvl[c];
            end
         end
`else
         sv = rj;
`endif
         rise = sv & ~m_sprev;
         fall = ~sv & m_sprev;
         ev   = '0;
         if (j > PRIME) begin
            case (mode)
               2'd0:    ev = rise | fall;
               2'd1:    ev = rise;
               2'd2:    ev = fall;
               default: ev = '0;
            endcase
         end
         m_sprev = sv;
         m_any   = |m_pulse;
         m_pulse = ev;
         for (int c = 0; c < N; c++) begin
            if (clear) begin
               m_sticky[c] = 1'b0;
               m_cnt[c]    = '0;
            end else if (ev[c]) begin
               m_sticky[c] = 1'b1;
               if (m_cnt[c] != {CW{1'b1}}) m_cnt[c] = m_cnt[c] + CW'(1);
            end
         end
      end
      for (int c = 0; c < N; c++) m_count_flat[c*CW +: CW] = m_cnt[c];
      #1;
      chk("model_pulse",  64'(pulse),  64'(m_pulse));
      chk("model_sticky", 64'(sticky), 64'(m_sticky));
      chk("model_count",  64'(count),  64'(m_count_flat));
      chk("model_any",    64'(any),    64'(m_any));
   end

   task automatic pulse_seq(input string name, input logic [N-1:0] exp);
      repeat (LAT-1) @(posedge clk);
      #2 chk({name, "_early"}, 64'(pulse), 64'(0));
      @(posedge clk);
      #2 chk(name, 64'(pulse), 64'(exp));
      @(posedge clk);
      #2 chk({name, "_once"}, 64'(pulse), 64'(0));
      chk({name, "_any"}, 64'(any), 64'(1));
      @(negedge clk);
   endtask

   task automatic set_hold(input int ch, input logic v, input int cycles);
      din[ch] = v;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic toggle4(input int ch);
      set_hold(ch, 1'b1, HOLD);
      set_hold(ch, 1'b0, HOLD);
      set_hold(ch, 1'b1, HOLD);
      set_hold(ch, 1'b0, HOLD);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; din = '1; mode = 2'b00; clear = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_pulse", 64'(pulse), 64'(0));
      chk("reset_count", 64'(count), 64'(0));
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("prime_pulse",  64'(pulse),  64'(0));
      chk("prime_sticky", 64'(sticky), 64'(0));
      chk("prime_count",  64'(count),  64'(0));

      // all four channels fall on the same edge
      din = '0;
      pulse_seq("all_fall", 4'hF);
      chk("all_fall_count", 64'(count), 64'h1111);
      do_clear();
      chk("clear_sticky", 64'(sticky), 64'(0));
      chk("clear_count",  64'(count),  64'(0));

      // both-edge mode on channel 0
      din[0] = 1'b1;
      pulse_seq("ch0_rise", 4'b0001);
      repeat (2) @(negedge clk);
      din[0] = 1'b0;
      pulse_seq("ch0_fall", 4'b0001);
      chk("ch0_count",  64'(count),  64'h0002);
      chk("ch0_sticky", 64'(sticky), 64'(4'b0001));

      // rising-only, falling-only, disabled on channel 2
      do_clear();
      mode = 2'b01;
      toggle4(2);
      chk("rise_only_count", 64'(count), 64'h0200);
      do_clear();
      mode = 2'b10;
      toggle4(2);
      chk("fall_only_count", 64'(count), 64'h0200);
      do_clear();
      mode = 2'b11;
      toggle4(2);
      chk("disabled_count",  64'(count),  64'(0));
      chk("disabled_sticky", 64'(sticky), 64'(0));

      // saturation, then clear colliding with an event
      do_clear();
      mode = 2'b01;
      for (int n = 0; n < 20; n++) begin
         set_hold(1, 1'b1, HOLD);
         set_hold(1, 1'b0, HOLD);
      end
      chk("sat_count",  64'(count),  64'h00F0);
      chk("sat_sticky", 64'(sticky), 64'(4'b0010));
      din[1] = 1'b1;
      repeat (LAT-1) @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #2 chk("collide_pulse", 64'(pulse), 64'(4'b0010));
      chk("collide_count",  64'(count),  64'(0));
      chk("collide_sticky", 64'(sticky), 64'(0));
      @(negedge clk);
      clear = 1'b0;
      set_hold(1, 1'b0, HOLD);

      // simultaneous rise, then reset during a pulse
      mode = 2'b00;
      do_clear();
      din = '1;
      pulse_seq("all_rise", 4'hF);
      repeat (2) @(negedge clk);
      din = '0;
      repeat (LAT) @(posedge clk);
      #2 chk("pre_reset_pulse", 64'(pulse), 64'hF);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_pulse",  64'(pulse),  64'(0));
      chk("async_rst_sticky", 64'(sticky), 64'(0));
      chk("async_rst_count",  64'(count),  64'(0));
      chk("async_rst_any",    64'(any),    64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("rearm_sticky", 64'(sticky), 64'(0));
      din[3] = 1'b1;
      pulse_seq("post_reset", 4'b1000);
      chk("post_reset_count", 64'(count), 64'h1000);

`ifdef DEBOUNCE_EN
      // short glitch is filtered, a held level produces exactly one pulse
      repeat (HOLD) @(negedge clk);
      do_clear();
      din[3] = 1'b0;
      repeat (3) @(negedge clk);
      din[3] = 1'b1;
      repeat (LAT + D) @(negedge clk);
      chk("glitch_sticky", 64'(sticky), 64'(0));
      din[3] = 1'b0;
      pulse_seq("deb_fall", 4'b1000);
      chk("deb_count", 64'(count), 64'h1000);
`endif

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
